// File: rtl/coupling_weight_loader.sv
// coupling_weight_loader
//   Loads the N x N coupling-weight matrix of a coupled-cell oscillator array
//   from one valid/ready stream of weight codes. Beats land in a shadow bank in
//   row-major order. The finished matrix is copied into the active bank in a
//   single cycle, so the array never sees a half-loaded configuration.
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset
//   start_i     pulse: begin a full-matrix load (honoured only when idle)
//   clear_i     pulse: set all active weights to the neutral code (idle only)
//   wt_valid_i  weight beat valid
//   wt_data_i   weight code for the current matrix entry
//   wt_ready_o  a beat is accepted this cycle when wt_valid_i is also high
//   busy_o      a load or commit is in progress
//   done_o      one-cycle pulse coincident with new contents on weights_o
//   err_o       sticky: an out-of-range code was dropped in the current/last load
//   weights_o   active bank; entry k = row*N + col at [k*WBITS +: WBITS]
module coupling_weight_loader #(
   parameter int N           = 4,
   parameter int NUM_WEIGHTS = 5,
   localparam int WBITS      = $clog2(NUM_WEIGHTS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     clear_i,
   input  logic                     wt_valid_i,
   input  logic [WBITS-1:0]         wt_data_i,
   output logic                     wt_ready_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [N*N*WBITS-1:0]     weights_o
);

   localparam int CELLS = N * N;
   localparam int IDXW  = $clog2(CELLS);
   // Zero-coupling code: equal delay for match and mismatch.
   localparam logic [WBITS-1:0] NEUTRAL  = WBITS'((NUM_WEIGHTS - 1) / 2);
   localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(CELLS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDXW-1:0]  idx;
   logic             ready;
   logic             done;
   logic             err;
   logic             beat;
   logic [WBITS-1:0] active [CELLS];
   logic [WBITS-1:0] shadow [CELLS];

   function automatic logic code_legal(input logic [WBITS-1:0] code);
      return int'(code) < NUM_WEIGHTS;
   endfunction

   assign beat = wt_valid_i & ready;

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_i) state_next = LOAD;
         LOAD:    if (beat && (idx == LAST_IDX)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         ready <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         for (int k = 0; k < CELLS; k++) begin
            active[k] <= NEUTRAL;
            shadow[k] <= NEUTRAL;
         end
      end else begin
         state <= state_next;
         // Registered ready: high for exactly the cycles spent in LOAD.
         ready <= (state_next == LOAD);
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  // Seed shadow from active so rejected codes keep the live value.
                  for (int k = 0; k < CELLS; k++) shadow[k] <= active[k];
                  idx <= '0;
                  err <= 1'b0;
               end else if (clear_i) begin
                  for (int k = 0; k < CELLS; k++) active[k] <= NEUTRAL;
                  done <= 1'b1;
               end
            end
            LOAD: begin
               if (beat) begin
                  if (code_legal(wt_data_i)) shadow[idx] <= wt_data_i;
                  else err <= 1'b1;
                  idx <= idx + IDXW'(1);
               end
            end
            COMMIT: begin
               for (int k = 0; k < CELLS; k++) active[k] <= shadow[k];
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign wt_ready_o = ready;
   assign busy_o     = (state != IDLE);
   assign done_o     = done;
   assign err_o      = err;

   always_comb begin
      weights_o = '0;
      for (int k = 0; k < CELLS; k++) weights_o[k*WBITS +: WBITS] = active[k];
   end

endmodule

// File: tb/tb_coupling_weight_loader.sv
// Testbench for coupling_weight_loader (N=4, NUM_WEIGHTS=5, WBITS=3).
// A driver issues loads/clears and pushes the expected matrix plus the cycle
// it must appear into a queue; a monitor pops on every done_o pulse and also
// checks that weights_o holds steady between commits.
module tb_coupling_weight_loader;

   localparam int N     = 4;
   localparam int NW    = 5;
   localparam int WB    = 3;
   localparam int CELLS = 16;
   localparam logic [47:0] NEUTRAL_W = {16{3'd2}};

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          clear_i;
   logic          wt_valid_i;
   logic [WB-1:0] wt_data_i;
   logic          wt_ready_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [47:0]   weights_o;

   coupling_weight_loader #(.N(N), .NUM_WEIGHTS(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .clear_i    (clear_i),
      .wt_valid_i (wt_valid_i),
      .wt_data_i  (wt_data_i),
      .wt_ready_o (wt_ready_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .weights_o  (weights_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [47:0] w;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   logic [47:0] model_cur = NEUTRAL_W;
   bit          mon_en = 1'b0;
   bit          in_rst = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [2:0]  codes [CELLS];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: scoreboard pop on done_o, stability check otherwise.
   always @(negedge clk) begin
      if (mon_en) begin
         if (in_rst) begin
            model_cur = NEUTRAL_W;
         end else if (done_o) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("done_cycle", 64'(cyc), 64'(e.cyc));
               chk("commit_weights", 64'(weights_o), 64'(e.w));
               model_cur = e.w;
            end
         end else begin
            chk("weights_stable", 64'(weights_o), 64'(model_cur));
            if (q.size() > 0 && cyc >= q[0].cyc) begin
               chk("done_missing", 64'd0, 64'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   // Full load of codes[]; optional random gaps, start+clear together,
   // start/clear pokes mid-load, and reset after abort_after beats.
   task automatic do_load(input bit gaps, input bit with_clear, input bit poke,
                          input int abort_after);
      logic [47:0] expw;
      bit          experr;
      int          e_last;
      expw   = model_cur;
      experr = 1'b0;
      for (int k = 0; k < CELLS; k++) begin
         if (int'(codes[k]) < NW) expw[k*WB +: WB] = codes[k];
         else experr = 1'b1;
      end
      start_i = 1'b1;
      clear_i = with_clear;
      @(negedge clk);
      start_i = 1'b0;
      clear_i = 1'b0;
      chk("busy_in_load", 64'(busy_o), 64'd1);
      chk("ready_after_start", 64'(wt_ready_o), 64'd1);
      chk("err_cleared_by_start", 64'(err_o), 64'd0);
      e_last = 0;
      for (int k = 0; k < CELLS; k++) begin
         if (k == abort_after) begin
            wt_valid_i = 1'b0;
            in_rst = 1'b1;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_weights", 64'(weights_o), 64'(NEUTRAL_W));
            chk("rst_busy", 64'(busy_o), 64'd0);
            chk("rst_ready", 64'(wt_ready_o), 64'd0);
            rst = 1'b0;
            @(negedge clk);
            in_rst = 1'b0;
            return;
         end
         if (gaps) begin
            while ($urandom_range(99) < 30) begin
               wt_valid_i = 1'b0;
               wt_data_i  = 3'($urandom);
               @(negedge clk);
            end
         end
         wt_valid_i = 1'b1;
         wt_data_i  = codes[k];
         if (poke && k == 7) begin
            start_i = 1'b1;
            clear_i = 1'b1;
         end
         chk("ready_in_load", 64'(wt_ready_o), 64'd1);
         e_last = cyc;
         @(negedge clk);
         start_i = 1'b0;
         clear_i = 1'b0;
      end
      wt_valid_i = 1'b0;
      chk("ready_drops", 64'(wt_ready_o), 64'd0);
      chk("busy_commit", 64'(busy_o), 64'd1);
      q.push_back('{w: expw, cyc: e_last + 2});
      wait_drain();
      chk("err_flag", 64'(err_o), 64'(experr));
      chk("idle_busy", 64'(busy_o), 64'd0);
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      q.push_back('{w: NEUTRAL_W, cyc: cyc + 1});
      @(negedge clk);
      clear_i = 1'b0;
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      start_i    = 1'b0;
      clear_i    = 1'b0;
      wt_valid_i = 1'b0;
      wt_data_i  = '0;
      repeat (3) @(negedge clk);
      chk("reset_weights", 64'(weights_o), 64'(NEUTRAL_W));
      chk("reset_ready", 64'(wt_ready_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_err", 64'(err_o), 64'd0);
      chk("reset_done", 64'(done_o), 64'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Back-to-back k%5.
      for (int k = 0; k < CELLS; k++) codes[k] = 3'(k % 5);
      do_load(1'b0, 1'b0, 1'b0, 99);

      // Clear, then the same matrix with random valid gaps.
      do_clear();
      do_load(1'b1, 1'b0, 1'b0, 99);

      // Illegal code on beat 5 keeps the prior value (0) and sets err.
      for (int k = 0; k < CELLS; k++) codes[k] = 3'd4;
      codes[5] = 3'd7;
      do_load(1'b0, 1'b0, 1'b0, 99);
      chk("err_entry5_kept", 64'(weights_o[5*WB +: WB]), 64'd0);

      // Start+clear together: load wins; pokes during LOAD ignored.
      for (int k = 0; k < CELLS; k++) codes[k] = 3'($urandom_range(0, 7));
      do_load(1'b1, 1'b1, 1'b1, 99);

      // Reset after 8 beats discards the load; fresh load afterwards.
      for (int k = 0; k < CELLS; k++) codes[k] = 3'($urandom_range(0, 4));
      do_load(1'b0, 1'b0, 1'b0, 8);
      chk("post_rst_weights", 64'(weights_o), 64'(NEUTRAL_W));
      for (int k = 0; k < CELLS; k++) codes[k] = 3'($urandom_range(0, 4));
      do_load(1'b1, 1'b0, 1'b0, 99);

      // Random mix.
      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(3) == 0) do_clear();
         for (int k = 0; k < CELLS; k++) codes[k] = 3'($urandom_range(0, 7));
         do_load(1'($urandom), 1'($urandom), 1'($urandom), 99);
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
